// File: rtl/sc_tx_port_arb_n.sv
// TX port arbiter: grants one of N requesters exclusive use of the shared
// SIE TX write port (fixed or round-robin priority, optional hold timeout).
module sc_tx_port_arb_n #(
  parameter int N        = 2,
  parameter int DW       = 8,
  parameter int CW       = 8,
  parameter int RR       = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          wen_in,
  input  logic [N*DW-1:0]       data_in,
  input  logic [N*CW-1:0]       cntl_in,
  output logic [N-1:0]          gnt,
  output logic [$clog2(N)-1:0]  gnt_idx,
  output logic                  port_wen,
  output logic [DW-1:0]         port_data,
  output logic [CW-1:0]         port_cntl,
  input  logic                  port_rdy_in,
  output logic [N-1:0]          rdy_out,
  output logic                  timeout
);

  localparam int IW   = $clog2(N);
  localparam int CNTW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {INIT, IDLE, GRANT} state_t;

  state_t          state;
  logic [N-1:0]    mask;
  logic [N-1:0]    elig;
  logic [CNTW-1:0] hold_cnt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic [N-1:0]    win_oh;
  logic            win_vld;

  assign elig = req & ~mask;

  // Round-robin scans from the slot after the last grantee, wrapping modulo N.
  always_comb begin
    win     = '0;
    win_oh  = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (RR != 0) cand = IW'((32'(gnt_idx) + k + 1) % N);
      else         cand = IW'(k);
      if (!win_vld && elig[cand]) begin
        win_vld      = 1'b1;
        win          = cand;
        win_oh       = '0;
        win_oh[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      gnt      <= '0;
      gnt_idx  <= IW'(N - 1);
      timeout  <= 1'b0;
      mask     <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      mask    <= mask & req;
      case (state)
        INIT: state <= IDLE;
        IDLE: begin
          if (win_vld) begin
            gnt      <= win_oh;
            gnt_idx  <= win;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request wins over a coincident timeout: no pulse, no mask.
          if (!req[gnt_idx]) begin
            gnt   <= '0;
            state <= IDLE;
          end else if ((MAX_HOLD > 0) && (hold_cnt == HOLD_LAST)) begin
            gnt           <= '0;
            mask[gnt_idx] <= 1'b1;
            timeout       <= 1'b1;
            state         <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    port_wen  = 1'b0;
    port_data = '0;
    port_cntl = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((|gnt) && (gnt_idx == IW'(i))) begin
        port_wen  = wen_in[i];
        port_data = data_in[i*DW +: DW];
        port_cntl = cntl_in[i*CW +: CW];
      end
    end
  end

  assign rdy_out = gnt & {N{port_rdy_in}};

endmodule

// File: tb/tb_sc_tx_port_arb_n.sv
// Directed bench for sc_tx_port_arb_n: fixed-priority/timeout instance (A)
// and round-robin instance (B), table rows plus multi-cycle sequences.
module tb_sc_tx_port_arb_n;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [31:0] cntl_in;

  logic [3:0] req_a, wen_a, gnt_a, rdy_out_a;
  logic       rdy_a, pwen_a, to_a;
  logic [1:0] idx_a;
  logic [7:0] pdata_a, pcntl_a;

  logic [3:0] req_b, wen_b, gnt_b, rdy_out_b;
  logic       rdy_b, pwen_b, to_b;
  logic [1:0] idx_b;
  logic [7:0] pdata_b, pcntl_b;

  int n_chk;
  int n_fail;

  sc_tx_port_arb_n #(.N(4), .DW(8), .CW(8), .RR(0), .MAX_HOLD(5)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .wen_in(wen_a), .data_in(data_in),
    .cntl_in(cntl_in), .gnt(gnt_a), .gnt_idx(idx_a), .port_wen(pwen_a),
    .port_data(pdata_a), .port_cntl(pcntl_a), .port_rdy_in(rdy_a),
    .rdy_out(rdy_out_a), .timeout(to_a)
  );

  sc_tx_port_arb_n #(.N(4), .DW(8), .CW(8), .RR(1), .MAX_HOLD(4)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .wen_in(wen_b), .data_in(data_in),
    .cntl_in(cntl_in), .gnt(gnt_b), .gnt_idx(idx_b), .port_wen(pwen_b),
    .port_data(pdata_b), .port_cntl(pcntl_b), .port_rdy_in(rdy_b),
    .rdy_out(rdy_out_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] wen;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
    logic       pwen;
    logic [7:0] pdata;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] dv [4];
    int         order [5];
    int         w;
    n_chk  = 0;
    n_fail = 0;
    dv     = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    order  = '{0, 1, 2, 3, 0};

    //          req      wen    rdy   gnt      idx   to    pwen  pdata
    tbl[0]  = '{4'b0011, 4'hF, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{4'b0011, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 8'hA0};
    tbl[2]  = '{4'b0011, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 8'hA0};
    tbl[3]  = '{4'b0010, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{4'b0010, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 8'hB1};
    tbl[5]  = '{4'b0010, 4'hD, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0, 8'hB1};
    tbl[6]  = '{4'b0000, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{4'b0000, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{4'b0100, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 8'hC2};
    tbl[9]  = '{4'b0110, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 8'hC2};
    tbl[10] = '{4'b0110, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 8'hC2};
    tbl[11] = '{4'b0110, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 8'hC2};
    tbl[12] = '{4'b0110, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 8'hC2};
    tbl[13] = '{4'b0110, 4'hF, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 8'h00};
    tbl[14] = '{4'b0110, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 8'hB1};
    tbl[15] = '{4'b0100, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{4'b0100, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[17] = '{4'b0000, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[18] = '{4'b0100, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 8'hC2};
    tbl[19] = '{4'b0000, 4'hF, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00};

    data_in = 32'hD3C2B1A0;
    cntl_in = 32'h7E6D5C4B;
    rst   = 1'b0;
    req_a = '0; wen_a = 4'hF; rdy_a = 1'b1;
    req_b = '0; wen_b = 4'hF; rdy_b = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt_a",   32'(gnt_a),     32'h0);
    chk("rst_idx_a",   32'(idx_a),     32'd3);
    chk("rst_to_a",    32'(to_a),      32'h0);
    chk("rst_pwen_a",  32'(pwen_a),    32'h0);
    chk("rst_pdata_a", 32'(pdata_a),   32'h0);
    chk("rst_pcntl_a", 32'(pcntl_a),   32'h0);
    chk("rst_rdy_a",   32'(rdy_out_a), 32'h0);
    chk("rst_idx_b",   32'(idx_b),     32'd3);
    chk("rst_gnt_b",   32'(gnt_b),     32'h0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_a = tbl[i].req;
      wen_a = tbl[i].wen;
      rdy_a = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_gnt", i),   32'(gnt_a),     32'(tbl[i].gnt));
      chk($sformatf("row%0d_idx", i),   32'(idx_a),     32'(tbl[i].idx));
      chk($sformatf("row%0d_to", i),    32'(to_a),      32'(tbl[i].to));
      chk($sformatf("row%0d_pwen", i),  32'(pwen_a),    32'(tbl[i].pwen));
      chk($sformatf("row%0d_pdata", i), 32'(pdata_a),   32'(tbl[i].pdata));
      chk($sformatf("row%0d_rdy", i),   32'(rdy_out_a), 32'(tbl[i].rdy ? tbl[i].gnt : 4'b0000));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a grant to requester 1.
    req_a = 4'b0010;
    @(posedge clk);
    #1;
    chk("mid_gnt",   32'(gnt_a),   32'b0010);
    chk("mid_pcntl", 32'(pcntl_a), 32'h5C);
    chk("mid_pwen",  32'(pwen_a),  32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt",   32'(gnt_a),   32'h0);
    chk("arst_pwen",  32'(pwen_a),  32'h0);
    chk("arst_pdata", 32'(pdata_a), 32'h0);
    chk("arst_idx",   32'(idx_a),   32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_edge1", 32'(gnt_a), 32'h0);
    cyc();
    chk("post_rst_edge2", 32'(gnt_a), 32'b0010);
    @(negedge clk);
    req_a = '0;

    // Round-robin on B: each grantee holds 3 cycles, drops, then re-raises.
    req_b = 4'hF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      w = order[i];
      chk($sformatf("rr%0d_gnt", i),   32'(gnt_b),   32'(4'b0001 << w));
      chk($sformatf("rr%0d_idx", i),   32'(idx_b),   32'(w));
      chk($sformatf("rr%0d_pdata", i), 32'(pdata_b), 32'(dv[w]));
      repeat (2) begin
        cyc();
        chk($sformatf("rr%0d_hold", i), 32'(gnt_b), 32'(4'b0001 << w));
      end
      @(negedge clk);
      req_b[w] = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_rel_gnt", i),  32'(gnt_b),  32'h0);
      chk($sformatf("rr%0d_rel_pwen", i), 32'(pwen_b), 32'h0);
      chk($sformatf("rr%0d_rel_to", i),   32'(to_b),   32'h0);
      @(negedge clk);
      req_b[w] = 1'b1;
      @(posedge clk);
      #1;
    end

    // Release coinciding with the timeout point on B (MAX_HOLD=4).
    @(negedge clk);
    req_b = '0;
    cyc();
    chk("tie_pre_idle", 32'(gnt_b), 32'h0);
    @(negedge clk);
    req_b = 4'b0010;
    @(posedge clk);
    #1;
    chk("tie_gnt", 32'(gnt_b), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("tie_hold%0d", i), 32'(gnt_b), 32'b0010);
    end
    @(negedge clk);
    req_b = '0;
    @(posedge clk);
    #1;
    chk("tie_rel_gnt", 32'(gnt_b), 32'h0);
    chk("tie_rel_to",  32'(to_b),  32'h0);
    @(negedge clk);
    req_b = 4'b0010;
    @(posedge clk);
    #1;
    chk("tie_regnt", 32'(gnt_b), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("b_hold%0d", i), 32'(gnt_b), 32'b0010);
    end
    cyc();
    chk("b_timeout_gnt", 32'(gnt_b), 32'h0);
    chk("b_timeout_to",  32'(to_b),  32'h1);
    cyc();
    chk("b_timeout_pulse_end", 32'(to_b),  32'h0);
    chk("b_masked_no_regnt",   32'(gnt_b), 32'h0);
    @(negedge clk);
    req_b = '0;
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
